kanji_mem_fetch: RTL and testbench

- Downstream of the Kanji ROM port decoder. Consumes its byte address and read strobe (`mem_addr`, `ram_ce`).
- Fetches the font byte from the shared SDRAM/BRAM port via a req/ack handshake.
- Holds the Z80 in wait until the byte is available, then drives it onto the CPU data bus for the rest of the I/O read.
- Sits between the Kanji decoder and the memory arbiter.

---
 rtl/kanji_mem_fetch_if.sv | 11 +
 rtl/kanji_mem_fetch.sv | 194 +++++++++++++++++++
 tb/tb_kanji_mem_fetch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/kanji_mem_fetch_if.sv
// Memory-side request channel between the Kanji fetch unit and the memory arbiter.
// req/req_addr are held until a single-cycle ack that carries rdata.
interface kanji_mem_fetch_if;
    logic        req;
    logic [26:0] req_addr;
    logic        ack;
    logic [7:0]  rdata;

    modport master (output req, req_addr, input ack, rdata);
    modport slave  (input req, req_addr, output ack, rdata);
endinterface

// File: rtl/kanji_mem_fetch.sv
// Kanji ROM byte fetch: turns a Z80 I/O read of a Kanji data port into a memory req/ack
// transaction, holding the CPU in wait until the byte arrives. Optional next-byte prefetch: KANJI_PREFETCH_EN.
module kanji_mem_fetch #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [26:0]        mem_addr,
    input  logic               ram_ce,
    input  logic               flush,
    output logic               cpu_wait,
    output logic [7:0]         dout,
    output logic               dout_oe,
    kanji_mem_fetch_if.master  mem
);
    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, PREFETCH} state_t;

    state_t          state_q, state_d;
    logic            ram_ce_q;
    logic            data_ready_q;
    logic [7:0]      dout_q;
    logic            req_q;
    logic [26:0]     req_addr_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            pend_q;
    logic [26:0]     pend_addr_q;

    logic            new_read, to_expire, pf_hit;
    logic [26:0]     rd_addr;
    logic [7:0]      pf_dout;
    logic            start, hit, fill, fill_ff, drop;

    assign new_read  = ram_ce & ~ram_ce_q;
    // A read deferred from DRAIN/PREFETCH uses the address captured at its own rising edge.
    assign rd_addr   = new_read ? mem_addr : pend_addr_q;
    assign to_expire = (to_cnt_q + 1'b1) == TO_W'(TIMEOUT);

`ifdef KANJI_PREFETCH_EN
    logic        pf_valid_q;
    logic [7:0]  pf_data_q;
    logic [26:0] pf_addr_q;
    logic        pf_start, pf_fill;

    assign pf_hit  = pf_valid_q && (rd_addr == pf_addr_q);
    assign pf_dout = pf_data_q;
`else
    logic flush_unused;
    assign flush_unused = flush;
    assign pf_hit       = 1'b0;
    assign pf_dout      = 8'hFF;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        hit     = 1'b0;
        fill    = 1'b0;
        fill_ff = 1'b0;
        drop    = 1'b0;
`ifdef KANJI_PREFETCH_EN
        pf_start = 1'b0;
        pf_fill  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (new_read || (pend_q && ram_ce)) begin
                    if (pf_hit) begin
                        hit     = 1'b1;
                        state_d = HOLD;
                    end else begin
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem.ack) begin
                    drop    = 1'b1;
                    fill    = ram_ce;
                    state_d = ram_ce ? HOLD : IDLE;
                end else if (to_expire) begin
                    drop    = 1'b1;
                    fill_ff = ram_ce;
                    state_d = ram_ce ? HOLD : IDLE;
                end else if (!ram_ce) begin
                    state_d = DRAIN;
                end
            end
            // The arbiter cannot cancel, so an aborted transaction is run to its ack.
            DRAIN: begin
                if (mem.ack) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!ram_ce) begin
`ifdef KANJI_PREFETCH_EN
                    pf_start = 1'b1;
                    state_d  = PREFETCH;
`else
                    state_d  = IDLE;
`endif
                end
            end
`ifdef KANJI_PREFETCH_EN
            PREFETCH: begin
                if (mem.ack) begin
                    drop    = 1'b1;
                    pf_fill = 1'b1;
                    state_d = IDLE;
                end else if (to_expire) begin
                    drop    = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_ce_q     <= 1'b0;
            data_ready_q <= 1'b0;
            dout_q       <= 8'hFF;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
            to_cnt_q     <= '0;
            pend_q       <= 1'b0;
        end else begin
            ram_ce_q <= ram_ce;

            if (start) begin
                req_q      <= 1'b1;
                req_addr_q <= rd_addr;
                to_cnt_q   <= '0;
            end
`ifdef KANJI_PREFETCH_EN
            else if (pf_start) begin
                req_q      <= 1'b1;
                req_addr_q <= {req_addr_q[26:5], req_addr_q[4:0] + 5'd1};
                to_cnt_q   <= '0;
            end
`endif
            else if (hit)  req_addr_q <= rd_addr;
            else if (drop) req_q      <= 1'b0;
            else if (state_q == REQ || state_q == PREFETCH) to_cnt_q <= to_cnt_q + 1'b1;

            if (fill)         dout_q <= mem.rdata;
            else if (fill_ff) dout_q <= 8'hFF;
            else if (hit)     dout_q <= pf_dout;

            if (fill || fill_ff || hit)         data_ready_q <= 1'b1;
            else if (state_q == HOLD && !ram_ce) data_ready_q <= 1'b0;

            if (state_q == IDLE) pend_q <= 1'b0;
            else if (new_read && (state_q == DRAIN || state_q == PREFETCH)) pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (new_read) pend_addr_q <= mem_addr;
    end

`ifdef KANJI_PREFETCH_EN
    always_ff @(posedge clk) begin
        if (reset) pf_valid_q <= 1'b0;
        else if (flush || pf_start) pf_valid_q <= 1'b0;
        else if (pf_fill)           pf_valid_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (pf_fill) begin
            pf_data_q <= mem.rdata;
            pf_addr_q <= req_addr_q;
        end
    end
`endif

    always_comb begin
        cpu_wait     = ram_ce & ~data_ready_q;
        dout_oe      = ram_ce & data_ready_q;
        dout         = dout_q;
        mem.req      = req_q;
        mem.req_addr = req_addr_q;
    end
endmodule

// File: tb/tb_kanji_mem_fetch.sv
// Directed bench for kanji_mem_fetch: basic read, timeout, CPU abort with deferred read,
// reset mid-request; next-byte prefetch hit/flush when KANJI_PREFETCH_EN is defined.
module tb_kanji_mem_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] mem_addr;
    logic        ram_ce;
    logic        flush;
    logic        cpu_wait;
    logic [7:0]  dout;
    logic        dout_oe;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n;

    kanji_mem_fetch_if mem_bus ();

    kanji_mem_fetch #(.TIMEOUT(64), .TO_W(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_addr (mem_addr),
        .ram_ce   (ram_ce),
        .flush    (flush),
        .cpu_wait (cpu_wait),
        .dout     (dout),
        .dout_oe  (dout_oe),
        .mem      (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ram_ce = 1'b0; flush = 1'b0; mem_addr = '0;
        mem_bus.ack = 1'b0; mem_bus.rdata = '0;
        tick; tick;
        reset = 1'b0; #1;
        chk("rst_req",      mem_bus.req, 0);
        chk("rst_req_addr", mem_bus.req_addr, 0);
        chk("rst_dout",     dout, 8'hFF);
        chk("rst_dout_oe",  dout_oe, 0);
        chk("rst_cpu_wait", cpu_wait, 0);

`ifndef KANJI_PREFETCH_EN
        // basic read, ack in the third cycle of req
        mem_addr = 27'h40; ram_ce = 1'b1; #1;
        chk("rd_wait_c0", cpu_wait, 1);
        chk("rd_req_c0",  mem_bus.req, 0);
        tick; #1;
        chk("rd_req_c1",  mem_bus.req, 1);
        chk("rd_addr_c1", mem_bus.req_addr, 27'h40);
        chk("rd_wait_c1", cpu_wait, 1);
        tick; #1;
        chk("rd_wait_c2", cpu_wait, 1);
        tick; mem_bus.ack = 1'b1; mem_bus.rdata = 8'h5A; #1;
        chk("rd_wait_c3", cpu_wait, 1);
        tick; mem_bus.ack = 1'b0; #1;
        chk("rd_wait_c4", cpu_wait, 0);
        chk("rd_req_c4",  mem_bus.req, 0);
        chk("rd_dout_c4", dout, 8'h5A);
        chk("rd_oe_c4",   dout_oe, 1);
        tick; #1;
        chk("rd_oe_c5",   dout_oe, 1);
        ram_ce = 1'b0; #1;
        chk("rd_oe_fall", dout_oe, 0);
        tick;

        // timeout: never ack
        mem_addr = 27'h1234; ram_ce = 1'b1; tick;
        n = 0;
        while (mem_bus.req === 1'b1 && n < 200) begin n++; tick; end
        chk("to_len", n, 64);
        #1;
        chk("to_req",  mem_bus.req, 0);
        chk("to_dout", dout, 8'hFF);
        chk("to_wait", cpu_wait, 0);
        chk("to_oe",   dout_oe, 1);
        mem_bus.ack = 1'b1; mem_bus.rdata = 8'h11; tick; mem_bus.ack = 1'b0; #1;
        chk("to_late_ack", dout, 8'hFF);
        ram_ce = 1'b0; tick; tick;

        // CPU abort in REQ, with a new read arriving during DRAIN
        mem_addr = 27'h55; ram_ce = 1'b1; tick; #1;
        chk("ab_req_r1", mem_bus.req, 1);
        tick; ram_ce = 1'b0;
        tick;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ab_req_hold", mem_bus.req, 1);
            chk("ab_oe",       dout_oe, 0);
            tick;
        end
        mem_addr = 27'h66; ram_ce = 1'b1; #1;
        chk("ab_req_r5",  mem_bus.req, 1);
        chk("ab_wait_r5", cpu_wait, 1);
        tick; mem_addr = 27'h99; #1;
        chk("ab_req_r6", mem_bus.req, 1);
        chk("ab_oe_r6",  dout_oe, 0);
        tick; mem_bus.ack = 1'b1; mem_bus.rdata = 8'h77; #1;
        chk("ab_req_r7", mem_bus.req, 1);
        tick; mem_bus.ack = 1'b0; #1;
        chk("ab_req_r8",  mem_bus.req, 0);
        chk("ab_dout_r8", dout, 8'hFF);
        chk("ab_oe_r8",   dout_oe, 0);
        chk("ab_wait_r8", cpu_wait, 1);
        tick; #1;
        chk("pend_req",  mem_bus.req, 1);
        chk("pend_addr", mem_bus.req_addr, 27'h66);
        mem_bus.ack = 1'b1; mem_bus.rdata = 8'h3C; tick; mem_bus.ack = 1'b0; #1;
        chk("pend_dout", dout, 8'h3C);
        chk("pend_oe",   dout_oe, 1);
        chk("pend_wait", cpu_wait, 0);
        ram_ce = 1'b0; tick; tick;

        // reset while a request is outstanding
        mem_addr = 27'h100; ram_ce = 1'b1; tick; #1;
        chk("rr_req_before", mem_bus.req, 1);
        reset = 1'b1; tick; #1;
        chk("rr_req",      mem_bus.req, 0);
        chk("rr_dout",     dout, 8'hFF);
        chk("rr_wait",     cpu_wait, 1);
        chk("rr_req_addr", mem_bus.req_addr, 0);
        chk("rr_oe",       dout_oe, 0);
        reset = 1'b0; ram_ce = 1'b0; tick; tick; #1;
        chk("rr_idle_req", mem_bus.req, 0);
`else
        // read 0x3F, prefetch wraps inside the glyph to 0x20
        mem_addr = 27'h3F; ram_ce = 1'b1; tick; #1;
        chk("pf_rd_addr", mem_bus.req_addr, 27'h3F);
        mem_bus.ack = 1'b1; mem_bus.rdata = 8'hA1; tick; mem_bus.ack = 1'b0; #1;
        chk("pf_rd_dout", dout, 8'hA1);
        chk("pf_rd_oe",   dout_oe, 1);
        ram_ce = 1'b0; tick; #1;
        chk("pf_req",      mem_bus.req, 1);
        chk("pf_req_addr", mem_bus.req_addr, 27'h20);
        chk("pf_wait",     cpu_wait, 0);
        mem_bus.ack = 1'b1; mem_bus.rdata = 8'hB2; tick; mem_bus.ack = 1'b0; #1;
        chk("pf_done_req", mem_bus.req, 0);
        mem_addr = 27'h20; ram_ce = 1'b1; #1;
        chk("hit_wait_c0", cpu_wait, 1);
        tick; #1;
        chk("hit_wait_c1", cpu_wait, 0);
        chk("hit_req",     mem_bus.req, 0);
        chk("hit_dout",    dout, 8'hB2);
        chk("hit_oe",      dout_oe, 1);
        chk("hit_addr",    mem_bus.req_addr, 27'h20);
        ram_ce = 1'b0; tick; #1;
        chk("pf2_req",  mem_bus.req, 1);
        chk("pf2_addr", mem_bus.req_addr, 27'h21);
        mem_bus.ack = 1'b1; mem_bus.rdata = 8'hC3; tick; mem_bus.ack = 1'b0;
        flush = 1'b1; tick; flush = 1'b0;
        mem_addr = 27'h21; ram_ce = 1'b1; tick; #1;
        chk("miss_req",  mem_bus.req, 1);
        chk("miss_addr", mem_bus.req_addr, 27'h21);
        chk("miss_wait", cpu_wait, 1);
        mem_bus.ack = 1'b1; mem_bus.rdata = 8'hD4; tick; mem_bus.ack = 1'b0; #1;
        chk("miss_dout", dout, 8'hD4);
        ram_ce = 1'b0; tick; tick;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
